dmi_dm_endpoint: RTL and testbench

//  DM-side endpoint of the DMI link. Receives 4-phase request handshakes from the JTAG DTM.
//  The DTM runs on TCK; this block runs on the core clock. It decodes op/addr/data and runs
//  one access on the DM register bus. It then returns {addr,data,op} to the DTM through a
//  4-phase response handshake. Only one transaction is in flight at a time.

---
 rtl/dmi_dm_endpoint.sv | 155 +++++++++++++++
 tb/tb_dmi_dm_endpoint.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmi_dm_endpoint.sv
// rtl/dmi_dm_endpoint.sv - DM-side DMI endpoint: 4-phase CDC handshake to a single register-bus access.
// Optional access timeout enabled by defining DMI_TIMEOUT_EN.
module dmi_dm_endpoint #(
  parameter int DMI_ADDR_BITS  = 6,
  parameter int DMI_DATA_BITS  = 32,
  parameter int DMI_OP_BITS    = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                                           clk_i,
  input  logic                                           rst_i,
  input  logic                                           dtm_req_i,
  input  logic [DMI_ADDR_BITS+DMI_DATA_BITS+DMI_OP_BITS-1:0] dtm_req_data_i,
  output logic                                           dm_ack_o,
  output logic                                           dm_resp_o,
  output logic [DMI_ADDR_BITS+DMI_DATA_BITS+DMI_OP_BITS-1:0] dm_resp_data_o,
  input  logic                                           dtm_ack_i,
  output logic                                           reg_valid_o,
  output logic                                           reg_we_o,
  output logic [DMI_ADDR_BITS-1:0]                       reg_addr_o,
  output logic [DMI_DATA_BITS-1:0]                       reg_wdata_o,
  input  logic [DMI_DATA_BITS-1:0]                       reg_rdata_i,
  input  logic                                           reg_ready_i
);

  localparam int REQ_BITS = DMI_ADDR_BITS + DMI_DATA_BITS + DMI_OP_BITS;
  localparam logic [DMI_OP_BITS-1:0] OP_NOP   = DMI_OP_BITS'(0);
  localparam logic [DMI_OP_BITS-1:0] OP_READ  = DMI_OP_BITS'(1);
  localparam logic [DMI_OP_BITS-1:0] OP_WRITE = DMI_OP_BITS'(2);
  localparam logic [DMI_OP_BITS-1:0] OP_OK    = DMI_OP_BITS'(0);
  localparam logic [DMI_OP_BITS-1:0] OP_FAIL  = DMI_OP_BITS'(2);
  localparam logic [DMI_DATA_BITS-1:0] DATA_ZERO = '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ_LOW,
    S_ACCESS,
    S_RESP,
    S_RESP_LOW
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            req_sync_q, ack_sync_q;
  logic [REQ_BITS-1:0]   req_q, req_d;
  logic                  ack_q, ack_d;
  logic                  resp_q, resp_d;
  logic [REQ_BITS-1:0]   resp_data_q, resp_data_d;
  logic                  req_s, ack_s;

  logic [DMI_OP_BITS-1:0]   op;
  logic [DMI_DATA_BITS-1:0] data;
  logic [DMI_ADDR_BITS-1:0] addr;

  assign req_s = req_sync_q[1];
  assign ack_s = ack_sync_q[1];
  assign op    = req_q[DMI_OP_BITS-1:0];
  assign data  = req_q[DMI_DATA_BITS+DMI_OP_BITS-1:DMI_OP_BITS];
  assign addr  = req_q[REQ_BITS-1:REQ_BITS-DMI_ADDR_BITS];

`ifdef DMI_TIMEOUT_EN
  localparam int CNT_BITS = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                timeout;

  // Counter sits at zero outside ACCESS, so it is cleared on every ACCESS entry.
  assign cnt_d   = (state_q == S_ACCESS) ? cnt_q + 1'b1 : '0;
  assign timeout = (cnt_q == CNT_BITS'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`endif

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    ack_d       = ack_q;
    resp_d      = resp_q;
    resp_data_d = resp_data_q;
    case (state_q)
      S_IDLE: begin
        if (req_s) begin
          req_d   = dtm_req_data_i;
          ack_d   = 1'b1;
          state_d = S_REQ_LOW;
        end
      end
      S_REQ_LOW: begin
        if (!req_s) begin
          ack_d = 1'b0;
          if (op == OP_READ || op == OP_WRITE) begin
            state_d = S_ACCESS;
          end else begin
            resp_data_d = {addr, DATA_ZERO, (op == OP_NOP) ? OP_OK : OP_FAIL};
            resp_d      = 1'b1;
            state_d     = S_RESP;
          end
        end
      end
      S_ACCESS: begin
        if (reg_ready_i) begin
          resp_data_d = {addr, (op == OP_READ) ? reg_rdata_i : DATA_ZERO, OP_OK};
          resp_d      = 1'b1;
          state_d     = S_RESP;
        end
`ifdef DMI_TIMEOUT_EN
        else if (timeout) begin
          resp_data_d = {addr, DATA_ZERO, OP_FAIL};
          resp_d      = 1'b1;
          state_d     = S_RESP;
        end
`endif
      end
      S_RESP: begin
        if (ack_s) begin
          resp_d  = 1'b0;
          state_d = S_RESP_LOW;
        end
      end
      S_RESP_LOW: begin
        if (!ack_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      req_sync_q  <= '0;
      ack_sync_q  <= '0;
      req_q       <= '0;
      ack_q       <= 1'b0;
      resp_q      <= 1'b0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      req_sync_q  <= {req_sync_q[0], dtm_req_i};
      ack_sync_q  <= {ack_sync_q[0], dtm_ack_i};
      req_q       <= req_d;
      ack_q       <= ack_d;
      resp_q      <= resp_d;
      resp_data_q <= resp_data_d;
    end
  end

  assign dm_ack_o       = ack_q;
  assign dm_resp_o      = resp_q;
  assign dm_resp_data_o = resp_data_q;
  assign reg_valid_o    = (state_q == S_ACCESS);
  assign reg_we_o       = reg_valid_o && (op == OP_WRITE);
  assign reg_addr_o     = reg_valid_o ? addr : '0;
  assign reg_wdata_o    = reg_valid_o ? data : '0;

endmodule

// File: tb/tb_dmi_dm_endpoint.sv
// tb/tb_dmi_dm_endpoint.sv - scoreboard bench for dmi_dm_endpoint (DTM driver, register responder, response monitor).
module tb_dmi_dm_endpoint;

`ifdef DMI_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int TO = 16;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        dtm_req_i;
  logic [39:0] dtm_req_data_i;
  logic        dm_ack_o;
  logic        dm_resp_o;
  logic [39:0] dm_resp_data_o;
  logic        dtm_ack_i;
  logic        reg_valid_o;
  logic        reg_we_o;
  logic [5:0]  reg_addr_o;
  logic [31:0] reg_wdata_o;
  logic [31:0] reg_rdata_i;
  logic        reg_ready_i;

  dmi_dm_endpoint #(
    .DMI_ADDR_BITS(6), .DMI_DATA_BITS(32), .DMI_OP_BITS(2), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .dtm_req_i(dtm_req_i), .dtm_req_data_i(dtm_req_data_i), .dm_ack_o(dm_ack_o),
    .dm_resp_o(dm_resp_o), .dm_resp_data_o(dm_resp_data_o), .dtm_ack_i(dtm_ack_i),
    .reg_valid_o(reg_valid_o), .reg_we_o(reg_we_o), .reg_addr_o(reg_addr_o),
    .reg_wdata_o(reg_wdata_o), .reg_rdata_i(reg_rdata_i), .reg_ready_i(reg_ready_i)
  );

  always #5 clk_i = ~clk_i;

  int tests = 0;
  int fails = 0;

  logic [39:0] exp_resp[$];
  int          lat_cfg   = 0;
  logic [31:0] rdata_cfg = '0;
  int          exp_vlen  = 0;
  logic        exp_we    = 1'b0;
  logic [5:0]  exp_addr  = '0;
  logic [31:0] exp_wdata = '0;
  bit          abort     = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Reference outcome of one DMI transaction.
  function automatic logic [39:0] model_resp(input logic [5:0] a, input logic [1:0] op,
                                             input logic [31:0] rd, input bit timed_out);
    if (op == 2'd1 && !timed_out) return {a, rd, 2'b00};
    if (op == 2'd0 || (op == 2'd2 && !timed_out)) return {a, 32'h0, 2'b00};
    return {a, 32'h0, 2'b10};
  endfunction

  task automatic issue(input logic [5:0] a, input logic [31:0] d, input logic [1:0] op,
                       input logic [31:0] rd, input int lat);
    bit to;
    to        = TO_EN && (lat >= TO);
    abort     = 1'b0;
    rdata_cfg = rd;
    lat_cfg   = lat;
    exp_we    = (op == 2'd2);
    exp_addr  = a;
    exp_wdata = d;
    exp_vlen  = (op == 2'd1 || op == 2'd2) ? (to ? TO : lat + 1) : 0;
    exp_resp.push_back(model_resp(a, op, rd, to));
    dtm_req_data_i = {a, d, op};
    dtm_req_i      = 1'b1;
  endtask

  task automatic wait_ack(input int edges);
    int n = 0;
    while (!dm_ack_o && n < 20) begin @(negedge clk_i); n++; end
    chk("ack_latency", n, edges);
  endtask

  task automatic drop_req();
    int n = 0;
    repeat ($urandom_range(0, 3)) begin
      @(negedge clk_i);
      chk("ack_held_while_req", dm_ack_o, 1);
    end
    dtm_req_i = 1'b0;
    while (dm_ack_o && n < 20) begin @(negedge clk_i); n++; end
    chk("ack_drop", dm_ack_o, 0);
  endtask

  task automatic wait_resp();
    int n = 0;
    while (!dm_resp_o && n < 500) begin @(negedge clk_i); n++; end
    chk("resp_wait", dm_resp_o, 1);
    repeat ($urandom_range(0, 3)) begin
      @(negedge clk_i);
      chk("resp_held", dm_resp_o, 1);
    end
  endtask

  task automatic ack_resp();
    int n = 0;
    dtm_ack_i = 1'b1;
    while (dm_resp_o && n < 20) begin @(negedge clk_i); n++; end
    chk("resp_drop", dm_resp_o, 0);
    dtm_ack_i = 1'b0;
  endtask

  task automatic run_txn(input logic [5:0] a, input logic [31:0] d, input logic [1:0] op,
                         input logic [31:0] rd, input int lat);
    issue(a, d, op, rd, lat);
    wait_ack(3);
    drop_req();
    wait_resp();
    ack_resp();
    repeat (4) @(negedge clk_i);
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_ack"}, dm_ack_o, 0);
    chk({nm, "_resp"}, dm_resp_o, 0);
    chk({nm, "_resp_data"}, dm_resp_data_o, 0);
    chk({nm, "_valid"}, reg_valid_o, 0);
    chk({nm, "_we"}, reg_we_o, 0);
    chk({nm, "_addr"}, reg_addr_o, 0);
    chk({nm, "_wdata"}, reg_wdata_o, 0);
  endtask

  // Register-bus responder and access checker.
  initial begin
    int  vcnt = 0;
    bit  vprev = 1'b0;
    reg_ready_i = 1'b0;
    reg_rdata_i = '0;
    forever begin
      @(negedge clk_i);
      if (reg_valid_o) begin
        chk("reg_we", reg_we_o, exp_we);
        chk("reg_addr", reg_addr_o, exp_addr);
        if (exp_we) chk("reg_wdata", reg_wdata_o, exp_wdata);
        reg_ready_i = (vcnt == lat_cfg);
        reg_rdata_i = reg_ready_i ? rdata_cfg : $urandom;
        vcnt++;
      end else begin
        if (vprev && !abort) chk("valid_cycles", vcnt, exp_vlen);
        vcnt = 0;
        reg_ready_i = $urandom_range(0, 1) == 1;
        reg_rdata_i = $urandom;
      end
      vprev = reg_valid_o;
    end
  end

  // Response monitor: pops the scoreboard on each new response.
  initial begin
    bit          rprev = 1'b0;
    logic [39:0] held  = '0;
    forever begin
      @(negedge clk_i);
      if (dm_resp_o && !rprev) begin
        if (exp_resp.size() == 0) begin
          tests++; fails++;
          $display("FAIL resp_unexpected actual=%0h expected=none", dm_resp_data_o);
        end else begin
          chk("resp_data", dm_resp_data_o, exp_resp.pop_front());
        end
        held = dm_resp_data_o;
      end else if (dm_resp_o) begin
        chk("resp_stable", dm_resp_data_o, held);
      end
      rprev = dm_resp_o;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1; dtm_req_i = 1'b0; dtm_req_data_i = '0; dtm_ack_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk_idle("reset");
    rst_i = 1'b0;
    @(negedge clk_i);

    run_txn(6'h11, 32'h0, 2'd1, 32'hDEADBEEF, 2);
    run_txn(6'h10, 32'h1, 2'd2, 32'h0, 3);
    run_txn(6'h05, 32'hFFFF_FFFF, 2'd0, 32'h0, 0);
    run_txn(6'h3F, 32'h1234_5678, 2'd3, 32'h0, 0);
    run_txn(6'h00, 32'hCAFE_F00D, 2'd1, 32'h0BAD_F00D, 0);

    // A second request raised during RESP must wait for the full 4-phase return.
    issue(6'h21, 32'h0, 2'd0, 32'h0, 0);
    wait_ack(3);
    drop_req();
    wait_resp();
    issue(6'h22, 32'hA5A5_5A5A, 2'd2, 32'h0, 1);
    repeat (6) begin
      @(negedge clk_i);
      chk("no_ack_during_resp", dm_ack_o, 0);
    end
    ack_resp();
    wait_ack(4);
    drop_req();
    wait_resp();
    ack_resp();
    repeat (4) @(negedge clk_i);

    // Reset while an access is pending.
    issue(6'h33, 32'h0, 2'd1, 32'h1111_2222, 1000);
    wait_ack(3);
    drop_req();
    repeat (2) @(negedge clk_i);
    chk("valid_before_rst", reg_valid_o, 1);
    abort = 1'b1;
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    chk_idle("rst_access");
    exp_resp.delete();
    run_txn(6'h34, 32'h0, 2'd1, 32'h3333_4444, 1);

    // Reset while the response is pending.
    issue(6'h35, 32'h0, 2'd0, 32'h0, 0);
    wait_ack(3);
    drop_req();
    wait_resp();
    abort = 1'b1;
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    chk_idle("rst_resp");
    run_txn(6'h36, 32'h7777_8888, 2'd2, 32'h0, 0);

`ifdef DMI_TIMEOUT_EN
    run_txn(6'h2A, 32'h0, 2'd1, 32'h5555_AAAA, 1000);
    run_txn(6'h2B, 32'h0, 2'd1, 32'h6666_BBBB, TO - 1);
`endif

    for (int i = 0; i < 30; i++) begin
      run_txn(6'($urandom), $urandom, 2'($urandom_range(0, 3)), $urandom, $urandom_range(0, 5));
    end

    chk("resp_queue_empty", exp_resp.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
